// File: rtl/vec_addsub_unit.sv
// Multi-cycle vector add/subtract unit: LANES elements per beat, per-element signed-overflow flags.
// Define VEC_ADDSUB_SAT_EN to honour op_sat (signed saturation); otherwise results always wrap.
module vec_addsub_unit #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int VLEN  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic                    op_sat,
    input  logic [VLEN*WIDTH-1:0]   in_a,
    input  logic [VLEN*WIDTH-1:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [VLEN*WIDTH-1:0]   out_res,
    output logic [VLEN-1:0]         out_ovf
);

    localparam int NBEATS = VLEN / LANES;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [VLEN*WIDTH-1:0]   a_q, a_d;
    logic [VLEN*WIDTH-1:0]   b_q, b_d;
    logic                    sub_q, sub_d;
    logic                    sat_q, sat_d;
    logic [VLEN*WIDTH-1:0]   res_q, res_d;
    logic [VLEN-1:0]         ovf_q, ovf_d;
    logic                    load;
    logic                    satActive;

`ifdef VEC_ADDSUB_SAT_EN
    assign satActive = sat_q;
`else
    assign satActive = 1'b0;
`endif

    // Returns {ovf, result}; each element is independent, no carry crosses lanes.
    function automatic logic [WIDTH:0] laneCalc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             sub,
        input logic             sat
    );
        logic [WIDTH-1:0] bEff;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] r;
        logic             ovf;
        bEff = sub ? ~b : b;
        sum  = a + bEff + {{(WIDTH-1){1'b0}}, sub};
        ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        r    = sum;
        if (sat && ovf) begin
            r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return {ovf, r};
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign load      = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        int idx;
        logic [WIDTH:0] laneOut;
        idx     = 0;
        laneOut = '0;
        state_d = state_q;
        beat_d  = beat_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sat_d   = sat_q;
        res_d   = res_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    idx     = int'(beat_q) * LANES + l;
                    laneOut = laneCalc(a_q[idx*WIDTH +: WIDTH], b_q[idx*WIDTH +: WIDTH],
                                       sub_q, satActive);
                    res_d[idx*WIDTH +: WIDTH] = laneOut[WIDTH-1:0];
                    ovf_d[idx]                = laneOut[WIDTH];
                end
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    state_d = DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Back-to-back issue from DONE shares this capture path with IDLE.
        if (load) begin
            a_d    = in_a;
            b_d    = in_b;
            sub_d  = op_sub;
            sat_d  = op_sat;
            beat_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sat_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sat_q   <= sat_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_vec_addsub_unit.sv
// Table-driven bench for vec_addsub_unit (WIDTH=8, LANES=4, VLEN=16), plus backpressure and reset sequences.
module tb_vec_addsub_unit;

    localparam int W  = 8;
    localparam int NV = 16;
    localparam int NT = 8;
`ifdef VEC_ADDSUB_SAT_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct {
        logic [NV*W-1:0] a;
        logic [NV*W-1:0] b;
        logic            sub;
        logic            sat;
        logic [NV*W-1:0] expRes;
        logic [NV-1:0]   expOvf;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic            op_sub;
    logic            op_sat;
    logic [NV*W-1:0] in_a;
    logic [NV*W-1:0] in_b;
    logic            out_valid;
    logic            out_ready;
    logic [NV*W-1:0] out_res;
    logic [NV-1:0]   out_ovf;

    vec_t tbl [NT];
    int   testsRun;
    int   testsFailed;

    vec_addsub_unit #(.WIDTH(W), .LANES(4), .VLEN(NV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .op_sat    (op_sat),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [NV*W-1:0] act, input logic [NV*W-1:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic setElem(input int k, input int e, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] r, input logic o);
        tbl[k].a[e*W +: W]      = a;
        tbl[k].b[e*W +: W]      = b;
        tbl[k].expRes[e*W +: W] = r;
        tbl[k].expOvf[e]        = o;
    endtask

    task automatic waitResult(output int edges);
        edges = 0;
        while (out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    // Drives one operation, lets the inputs change after acceptance, and checks latency and result.
    task automatic applyStimulus(input int k);
        int edges;
        @(negedge clk);
        in_a     = tbl[k].a;
        in_b     = tbl[k].b;
        op_sub   = tbl[k].sub;
        op_sat   = tbl[k].sat;
        in_valid = 1'b1;
        checkOutput($sformatf("vec%0d in_ready", k), {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom, $urandom, $urandom};
        in_b     = {$urandom, $urandom, $urandom, $urandom};
        op_sub   = ~op_sub;
        op_sat   = ~op_sat;
        waitResult(edges);
        checkOutput($sformatf("vec%0d latency", k), 128'(edges), 128'd4);
        checkOutput($sformatf("vec%0d out_res", k), out_res, tbl[k].expRes);
        checkOutput($sformatf("vec%0d out_ovf", k), {112'd0, out_ovf}, {112'd0, tbl[k].expOvf});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput($sformatf("vec%0d drained", k), {127'd0, out_valid}, 128'd0);
    endtask

    initial begin
        int edges;
        int badCycles;
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op_sub      = 1'b0;
        op_sat      = 1'b0;
        in_a        = '0;
        in_b        = '0;
        out_ready   = 1'b0;

        for (int k = 0; k < NT; k++) begin
            tbl[k].a = '0; tbl[k].b = '0; tbl[k].sub = 1'b0; tbl[k].sat = 1'b0;
            tbl[k].expRes = '0; tbl[k].expOvf = '0;
        end
        tbl[2].sub = 1'b1;
        tbl[3].sub = 1'b1;
        tbl[5].sat = 1'b1;
        tbl[6].sat = 1'b1;
        tbl[7].sub = 1'b1;
        tbl[7].sat = 1'b1;
        for (int e = 0; e < NV; e++) begin
            setElem(0, e, 8'h05, 8'h03, 8'h08, 1'b0);
            setElem(1, e, 8'(e), 8'(2*e), 8'(3*e), 1'b0);
            setElem(2, e, 8'h10, 8'h20, 8'hF0, 1'b0);
            if (e == 0) setElem(3, e, 8'h80, 8'h01, 8'h7F, 1'b1);
            else        setElem(3, e, 8'h10, 8'h20, 8'hF0, 1'b0);
            setElem(4, e, 8'h7F, 8'h01, 8'h80, 1'b1);
            setElem(5, e, 8'h7F, 8'h01, SAT_ON ? 8'h7F : 8'h80, 1'b1);
            setElem(6, e, 8'h80, 8'hFF, SAT_ON ? 8'h80 : 8'h7F, 1'b1);
            if (e % 2 == 0) setElem(7, e, 8'h7F, 8'hFF, SAT_ON ? 8'h7F : 8'h80, 1'b1);
            else            setElem(7, e, 8'h01, 8'h02, 8'hFF, 1'b0);
        end

        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("reset out_res", out_res, 128'd0);
        checkOutput("reset out_ovf", {112'd0, out_ovf}, 128'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready", {127'd0, in_ready}, 128'd1);

        for (int k = 0; k < NT; k++) begin
            applyStimulus(k);
        end

        // Backpressure: result held in DONE, then drained with a back-to-back issue.
        @(negedge clk);
        in_a = tbl[0].a; in_b = tbl[0].b; op_sub = tbl[0].sub; op_sat = tbl[0].sat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waitResult(edges);
        checkOutput("bp first latency", 128'(edges), 128'd4);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp hold%0d out_valid", c), {127'd0, out_valid}, 128'd1);
            checkOutput($sformatf("bp hold%0d out_res", c), out_res, tbl[0].expRes);
            checkOutput($sformatf("bp hold%0d in_ready", c), {127'd0, in_ready}, 128'd0);
        end
        in_a = tbl[2].a; in_b = tbl[2].b; op_sub = tbl[2].sub; op_sat = tbl[2].sat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("b2b in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b out_valid low", {127'd0, out_valid}, 128'd0);
        waitResult(edges);
        checkOutput("b2b latency", 128'(edges), 128'd4);
        checkOutput("b2b out_res", out_res, tbl[2].expRes);
        checkOutput("b2b out_ovf", {112'd0, out_ovf}, {112'd0, tbl[2].expOvf});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset during beat 2 aborts the operation immediately.
        @(negedge clk);
        in_a = tbl[0].a; in_b = tbl[0].b; op_sub = 1'b0; op_sat = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", {127'd0, out_valid}, 128'd0);
        checkOutput("abort out_res", out_res, 128'd0);
        checkOutput("abort out_ovf", {112'd0, out_ovf}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort in_ready", {127'd0, in_ready}, 128'd1);
        badCycles = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) badCycles++;
        end
        checkOutput("abort no result", 128'(badCycles), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
